// File: rtl/crc32_word_feeder.sv
// Byte-to-word packer and load/compute/capture sequencer for the crc32 engine.
// The packer refills while the engine works on the previous word.
module crc32_word_feeder #(
  parameter int unsigned COMPUTE_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        crc_rst_n_o,
  output logic        crc_compute_o,
  output logic [31:0] crc_msg_o,
  input  logic [31:0] crc_result_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_CAPTURE,
    S_OUTPUT
  } state_e;

  localparam logic [5:0] CYC_LAST = 6'(COMPUTE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  cyc_q, cyc_d;

  logic [31:0] pk_word_q, pk_word_d;
  logic [2:0]  pk_cnt_q, pk_cnt_d;
  logic        pk_last_q, pk_last_d;

  logic [31:0] msg_q, msg_d;
  logic        eng_last_q, eng_last_d;

  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_valid_q, out_valid_d;
  logic        crc_rst_n_q, crc_rst_n_d;
  logic        crc_compute_q, crc_compute_d;

  logic        pk_full;
  logic        accept;
  logic        xfer;

  assign pk_full    = (pk_cnt_q == 3'd4) | pk_last_q;
  assign in_ready_o = ~pk_full & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign xfer       = (state_q == S_IDLE) & pk_full;

  // Packer: place bytes big-endian, empty it when the engine takes the word.
  always_comb begin
    pk_word_d = pk_word_q;
    pk_cnt_d  = pk_cnt_q;
    pk_last_d = pk_last_q;
    if (xfer) begin
      pk_word_d = '0;
      pk_cnt_d  = '0;
      pk_last_d = 1'b0;
    end else if (accept) begin
      unique case (pk_cnt_q[1:0])
        2'd0: pk_word_d[31:24] = in_data_i;
        2'd1: pk_word_d[23:16] = in_data_i;
        2'd2: pk_word_d[15:8]  = in_data_i;
        2'd3: pk_word_d[7:0]   = in_data_i;
        default: pk_word_d     = pk_word_q;
      endcase
      pk_cnt_d  = pk_cnt_q + 3'd1;
      pk_last_d = in_last_i;
    end
  end

  // Engine sequencer next state and compute-cycle counter.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (pk_full) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_COMPUTE;
        cyc_d   = '0;
      end
      S_COMPUTE: begin
        if (cyc_q == CYC_LAST) state_d = S_CAPTURE;
        else cyc_d = cyc_q + 6'd1;
      end
      S_CAPTURE: begin
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Engine word register, result capture and strobes decoded from next state.
  always_comb begin
    msg_d         = msg_q;
    eng_last_d    = eng_last_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    if (xfer) begin
      msg_d      = pk_word_q;
      eng_last_d = pk_last_q;
    end
    if (state_q == S_CAPTURE) begin
      out_data_d = crc_result_i;
      out_last_d = eng_last_q;
    end
    crc_rst_n_d   = (state_d != S_LOAD);
    crc_compute_d = (state_d == S_COMPUTE);
    out_valid_d   = (state_d == S_OUTPUT);
  end

  // State registers; reset holds the engine in reset and drops all valids.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      pk_word_q     <= '0;
      pk_cnt_q      <= '0;
      pk_last_q     <= 1'b0;
      msg_q         <= '0;
      eng_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      crc_rst_n_q   <= 1'b0;
      crc_compute_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      pk_word_q     <= pk_word_d;
      pk_cnt_q      <= pk_cnt_d;
      pk_last_q     <= pk_last_d;
      msg_q         <= msg_d;
      eng_last_q    <= eng_last_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
      crc_rst_n_q   <= crc_rst_n_d;
      crc_compute_q <= crc_compute_d;
    end
  end

  assign crc_rst_n_o   = crc_rst_n_q;
  assign crc_compute_o = crc_compute_q;
  assign crc_msg_o     = msg_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;
  assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_crc32_word_feeder.sv
// Scoreboard bench for crc32_word_feeder with a stub engine
// that returns ~msg in the capture cycle.
module tb_crc32_word_feeder;

  localparam int CC = 32;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  in_data_i = 8'h0;
  logic        in_valid_i = 1'b0;
  logic        in_last_i = 1'b0;
  logic        in_ready_o;
  logic        crc_rst_n_o;
  logic        crc_compute_o;
  logic [31:0] crc_msg_o;
  logic [31:0] crc_result_i;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int last_acc = 0;
  bit prev_comp = 1'b0;
  bit was_rst = 1'b1;
  bit rand_rdy = 1'b0;
  bit rdy_set = 1'b1;
  bit auto_exp = 1'b0;

  logic [31:0] exp_msg[$];
  logic [32:0] exp_res[$];
  int hs_q[$];
  int load_q[$];
  int rise_q[$];

  logic [31:0] ref_w = 32'h0;
  int ref_n = 0;

  crc32_word_feeder #(.COMPUTE_CYCLES(CC)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .in_data_i(in_data_i),
    .in_valid_i(in_valid_i),
    .in_last_i(in_last_i),
    .in_ready_o(in_ready_o),
    .crc_rst_n_o(crc_rst_n_o),
    .crc_compute_o(crc_compute_o),
    .crc_msg_o(crc_msg_o),
    .crc_result_i(crc_result_i),
    .out_data_o(out_data_o),
    .out_last_o(out_last_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt   <= cyc_cnt + 1;
    prev_comp <= crc_compute_o;
    was_rst   <= rst_i;
  end

  assign crc_result_i = (prev_comp && !crc_compute_o) ? ~crc_msg_o : 32'h0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] m, input logic [31:0] r,
                             input logic l);
    exp_msg.push_back(m);
    exp_res.push_back({l, r});
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data_i  = d;
    in_last_i  = l;
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: byte %h not accepted", d);
    end
    @(posedge clk); #1;
    last_acc   = cyc_cnt;
    in_valid_i = 1'b0;
    if (auto_exp) begin
      ref_w[31-8*ref_n -: 8] = d;
      ref_n++;
      if (ref_n == 4 || l) begin
        expect_word(ref_w, ~ref_w, l);
        ref_w = 32'h0;
        ref_n = 0;
      end
    end
  endtask

  task automatic drain(input string nm, input int maxc);
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_msg.size() != 0 || out_valid_o)
           && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain"}, exp_res.size() + exp_msg.size(), 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
    end
  end

  int run = 0;
  bit prev_load = 1'b0;
  bit prev_v = 1'b0;
  bit prev_r = 1'b0;
  bit prev_l = 1'b0;
  logic [31:0] prev_d = 32'h0;

  // monitor: pops expectations whenever the DUT loads or hands off a result
  always @(negedge clk) begin
    if (!rst_i && !was_rst) begin
      if (prev_load)
        chk("load_len", {crc_rst_n_o, crc_compute_o}, 2'b11);
      if (!crc_rst_n_o) begin
        load_q.push_back(cyc_cnt);
        if (exp_msg.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_load: got msg %h want none", crc_msg_o);
        end else begin
          chk("msg", crc_msg_o, exp_msg.pop_front());
        end
      end
      if (!crc_compute_o && run > 0)
        chk("compute_len", run, CC);
      if (prev_v && !prev_r) begin
        chk("hold_data", {out_valid_o, out_data_o}, {1'b1, prev_d});
        chk("hold_last", out_last_o, prev_l);
      end
      if (out_valid_o && !prev_v)
        rise_q.push_back(cyc_cnt);
      if (out_valid_o && out_ready_i) begin
        hs_q.push_back(cyc_cnt);
        if (exp_res.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h want none", out_data_o);
        end else begin
          chk("result", {out_last_o, out_data_o}, exp_res.pop_front());
        end
      end
    end
    prev_load <= !rst_i && !was_rst && !crc_rst_n_o;
    run       <= crc_compute_o ? run + 1 : 0;
    prev_v    <= out_valid_o;
    prev_r    <= out_ready_i;
    prev_d    <= out_data_o;
    prev_l    <= out_last_o;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    // reset values
    rst_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_crc_rst_n", crc_rst_n_o, 0);
    chk("rst_compute", crc_compute_o, 0);
    chk("rst_msg", crc_msg_o, 0);
    chk("rst_out", {out_valid_o, out_last_o, out_data_o}, 0);
    chk("rst_in_ready", in_ready_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready_o, 1);
    @(posedge clk); #1;

    // single word, last on 4th byte, plus latency
    rise_q.delete();
    expect_word(32'h12345678, 32'hEDCBA987, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    n = last_acc;
    drain("single", 200);
    if (rise_q.size() >= 1) chk("latency", rise_q[0] - n + 1, 36);
    else chk("latency_rise", rise_q.size(), 1);

    // partial frame zero-padded
    expect_word(32'hAABB0000, 32'h5544FFFF, 1'b1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    drain("partial", 200);

    // last on the first byte
    expect_word(32'h5A000000, 32'hA5FFFFFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    drain("first_last", 200);

    // overlap: 8 back-to-back bytes
    hs_q.delete();
    load_q.delete();
    expect_word(32'h01020304, 32'hFEFDFCFB, 1'b0);
    expect_word(32'h05060708, 32'hFAF9F8F7, 1'b0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    chk("ovl_compute", crc_compute_o, 1);
    chk("ovl_full", in_ready_o, 0);
    drain("overlap", 300);
    if (load_q.size() >= 2 && hs_q.size() >= 1)
      chk("load_gap", load_q[1] - hs_q[0], 2);
    else
      chk("ovl_counts", {load_q.size(), hs_q.size()}, {32'd2, 32'd2});

    // back-pressure
    rdy_set = 1'b0;
    expect_word(32'h11223344, 32'hEEDDCCBB, 1'b0);
    expect_word(32'h55667788, 32'hAA998877, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    n = 0;
    while (!out_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", out_valid_o, 1);
    repeat (50) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready_o, 0);
    end
    rdy_set = 1'b1;
    drain("backpressure", 300);

    // reset mid-compute, with a partial byte that must be discarded
    expect_word(32'hDEADBEEF, 32'h21524110, 1'b1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    n = 0;
    while (!crc_compute_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    send_byte(8'h99, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_compute", crc_compute_o, 1);
    rst_i = 1'b1;
    exp_res.delete();
    exp_msg.delete();
    @(posedge clk); #1;
    chk("mid_rst_compute", crc_compute_o, 0);
    chk("mid_rst_crc_rst_n", crc_rst_n_o, 0);
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_out", {out_last_o, out_data_o}, 0);
    chk("mid_rst_msg", crc_msg_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 0);
    rst_i = 1'b0;
    #1;
    chk("mid_post_in_ready", in_ready_o, 1);
    @(posedge clk); #1;
    expect_word(32'hCAFEF00D, 32'h35010FF2, 1'b1);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0D, 1'b1);
    drain("after_rst", 200);

    // random stalls against the reference packer
    auto_exp = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      g = 0;
      while ($urandom_range(0, 1) == 1 && g < 8) begin
        @(posedge clk); #1;
        g++;
      end
      send_byte(8'($urandom_range(0, 255)),
                (i == 199) || ($urandom_range(0, 4) == 0));
    end
    drain("random", 20000);
    rand_rdy = 1'b0;
    auto_exp = 1'b0;

    chk("leftover", exp_res.size() + exp_msg.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc32_word_feeder.md
# crc32_word_feeder

Front end for the `crc32` engine. It accepts a byte stream with a valid/ready handshake and packs the bytes into 32-bit big-endian words, zero-padding a partial final word. For each word it drives the engine's load/compute sequence, then captures the engine result and presents it on a valid/ready output port. A byte packer and a separate engine word register let the next word fill while the current one computes.

## Interface
- `COMPUTE_CYCLES`, default 32: number of consecutive cycles `compute_o` is held high per word.
- `clk_i  input  1`: clock; the only clock domain.
- `rst_i  input  1`: reset, synchronous and active-high. One clock; all state clears on the `clk_i` edge at which `rst_i` is sampled high.
- `in_data_i  input  8`: input byte.
- `in_valid_i  input  1`: input byte valid.
- `in_last_i  input  1`: byte is the last of its frame.
- `in_ready_o  output  1`: packer can accept a byte.
- `crc_rst_n_o  output  1`: registered reset to the engine (active-low). Low loads `crc_msg_o` into the engine.
- `crc_compute_o  output  1`: registered compute strobe to the engine.
- `crc_msg_o  output  32`: engine word register, driven to the engine message input.
- `crc_result_i  input  32`: engine result.
- `out_data_o  output  32`: captured CRC result.
- `out_last_o  output  1`: result belongs to the last word of a frame.
- `out_valid_o  output  1`: result valid.
- `out_ready_i  input  1`: downstream accepts the result.

## Operation
- **Packer**
  - Holds `pk_word[31:0]`, `pk_cnt[2:0]` (0–4 bytes) and `pk_last`.
  - A byte is accepted when `in_valid_i & in_ready_o`. Byte n of the word (n = 0..3) goes to bits [31-8n -: 8].
  - `pk_full` = (`pk_cnt` == 4) | `pk_last`.
  - `in_ready_o` = !`pk_full` & !`rst_i`.
  - A byte with `in_last_i` sets `pk_last`; the unfilled low bytes stay 0.
- **Engine FSM states:** IDLE, LOAD, COMPUTE, CAPTURE, OUTPUT.
  - **IDLE:** if `pk_full`:
    - copy `pk_word` to `crc_msg_o` and `pk_last` to `eng_last`;
    - clear the packer (`pk_cnt`=0, `pk_last`=0, `pk_word`=0);
    - go to LOAD.
  - **Transfer and accept in the same cycle:** not possible, because `in_ready_o` is 0 while `pk_full`. The first accept into the freed packer is the following cycle.
  - **LOAD:** 1 cycle, `crc_rst_n_o`=0. Then go to COMPUTE with `cyc`=0.
  - **COMPUTE:** `crc_compute_o`=1 for exactly `COMPUTE_CYCLES` cycles, counted by `cyc` (6 bits). When `cyc` reaches `COMPUTE_CYCLES`-1, go to CAPTURE.
  - **CAPTURE:** 1 cycle, `crc_compute_o`=0. `out_data_o` <= `crc_result_i` and `out_last_o` <= `eng_last` at the closing edge. Then go to OUTPUT.
  - **OUTPUT:** `out_valid_o`=1. On `out_ready_i` go to IDLE. `out_data_o`/`out_last_o` are held stable while valid and not ready.
- `crc_msg_o` is held unchanged from LOAD through OUTPUT. The packer keeps filling during LOAD, COMPUTE, CAPTURE and OUTPUT.
- `crc_rst_n_o` and `crc_compute_o` are flops decoded from the next state, so both are glitch-free.

## Timing
- **Reset values:**
  - `crc_rst_n_o`=0, which holds the engine in reset for the reset cycle(s).
  - `crc_compute_o`=0, `crc_msg_o`=0, `out_data_o`=0, `out_last_o`=0, `out_valid_o`=0.
  - FSM=IDLE, packer empty.
  - `in_ready_o`=0 while `rst_i`=1 and 1 in the first cycle after.
- **Latency:** the packer becomes full at edge T. IDLE at T+1 transfers. The LOAD cycle is T+2. COMPUTE runs T+3..T+34. CAPTURE is T+35. `out_valid_o`=1 from T+36.
- **Per-word occupancy:** 2 + `COMPUTE_CYCLES` + 1 cycles, plus the output wait.
- **Throughput:** one word per `COMPUTE_CYCLES`+4 cycles when `out_ready_i`=1 and input is always valid. The packer fills in parallel with the engine.
- **Handshakes:** `in_valid_i` may rise or fall freely. An output transfer happens only on the edge where `out_valid_o` & `out_ready_i`. `out_ready_i` may be high before valid.
- **`in_last_i` on a fourth byte:** the word transfers once with `eng_last`=1; no extra all-zero word is generated.
- **`in_last_i` on the first byte:** the word is {byte, 24'h0} with `out_last_o`=1.
- **Back-pressure:** with the FSM in OUTPUT and the packer full, `in_ready_o` stays 0 until the FSM reaches IDLE and transfers.
- **Reset mid-operation:** `rst_i` in any state returns to IDLE on that edge, drops `out_valid_o`, empties the packer and drives `crc_rst_n_o`=0. Partial words are discarded.

## Test plan
- **Single word:** bytes 12,34,56,78 with last on 78, using a stub engine with `crc_result_i` = ~`crc_msg_o` only in CAPTURE (0 otherwise). Required:
  - `crc_msg_o`=32'h12345678;
  - `crc_rst_n_o` low for exactly 1 cycle;
  - `crc_compute_o` high for exactly 32 cycles;
  - `out_data_o`=32'hEDCBA987 with `out_last_o`=1;
  - `out_valid_o` rises 36 cycles after the edge accepting 78.
- **Partial frame:** bytes AA,BB with last on BB -> `crc_msg_o`=32'hAABB0000, `out_last_o`=1.
- **Overlap:** 8 back-to-back bytes 01..08 with `out_ready_i`=1. Required:
  - the second packer fills during the first COMPUTE;
  - results ~32'h01020304 then ~32'h05060708;
  - the second LOAD occurs 2 cycles after the first output handshake.
- **Back-pressure:** hold `out_ready_i`=0 for 50 cycles. Required: `out_data_o` stays stable, `in_ready_o`=0 once 4 further bytes are packed, and no output is lost or duplicated.
- **Reset mid-compute:** `rst_i` at COMPUTE cycle 10. Required:
  - next cycle `crc_compute_o`=0, `crc_rst_n_o`=0, `out_valid_o`=0;
  - all outputs at reset values;
  - a fresh word then completes normally.
- **Random stall:** random `in_valid_i`/`out_ready_i` at 50% over 200 bytes, checked against a reference packer/CRC model, with byte order and last flags preserved.
